// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory map with screen scan-out.
// Provides default geometry, the keyboard-address helper and the
// address-region decoder used by the top module.
package hack_mem_pkg;

  localparam int unsigned DEF_WIDTH        = 16;
  localparam int unsigned DEF_ADDR_W       = 15;
  localparam int unsigned DEF_RAM_DEPTH    = 16384;
  localparam int unsigned DEF_SCREEN_DEPTH = 8192;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_e;

  // Keyboard register sits directly after the screen buffer.
  function automatic int unsigned kbd_addr(input int unsigned ram_depth,
                                           input int unsigned screen_depth);
    return ram_depth + screen_depth;
  endfunction

  function automatic region_e decode_region(input int unsigned addr,
                                            input int unsigned ram_depth,
                                            input int unsigned screen_depth);
    if (addr < ram_depth)                               return REG_RAM;
    else if (addr < kbd_addr(ram_depth, screen_depth))  return REG_SCREEN;
    else if (addr == kbd_addr(ram_depth, screen_depth)) return REG_KBD;
    else                                                return REG_NONE;
  endfunction

endpackage

// File: rtl/hack_memory_map_scan_if.sv
// Bus bundle between the CPU/display side (master) and the memory map (slave).
// CPU port : in, load, address -> out (combinational read), bus_err
// Keyboard : kbd_in
// Scan-out : scan_en, scan_restart, scan_ready -> scan_data, scan_valid,
//            scan_frame_start
interface hack_memory_map_scan_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 15
);
  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  out;
  logic [WIDTH-1:0]  kbd_in;
  logic              bus_err;
  logic              scan_en;
  logic              scan_restart;
  logic [WIDTH-1:0]  scan_data;
  logic              scan_valid;
  logic              scan_ready;
  logic              scan_frame_start;

  modport master (
    output in, load, address, kbd_in, scan_en, scan_restart, scan_ready,
    input  out, bus_err, scan_data, scan_valid, scan_frame_start
  );

  modport slave (
    input  in, load, address, kbd_in, scan_en, scan_restart, scan_ready,
    output out, bus_err, scan_data, scan_valid, scan_frame_start
  );
endinterface

// File: rtl/hack_screen_dpram.sv
// Screen buffer: CPU read/write port (combinational read, synchronous write)
// plus a registered scan read port. On a same-address collision the scan
// port returns the word as it was before the CPU write.
// Ports: clk, reset (async, clears scan read register only),
//        cpu_we_i/cpu_addr_i/cpu_wdata_i/cpu_rdata_o,
//        scan_re_i/scan_addr_i/scan_rdata_o.
module hack_screen_dpram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8192,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_we_i,
  input  logic [AW-1:0]    cpu_addr_i,
  input  logic [WIDTH-1:0] cpu_wdata_i,
  output logic [WIDTH-1:0] cpu_rdata_o,
  input  logic             scan_re_i,
  input  logic [AW-1:0]    scan_addr_i,
  output logic [WIDTH-1:0] scan_rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] scan_rdata_q;

  // CPU write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (cpu_we_i) mem_q[cpu_addr_i] <= cpu_wdata_i;
  end

  // Scan read samples the pre-edge contents, giving read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          scan_rdata_q <= '0;
    else if (scan_re_i) scan_rdata_q <= mem_q[scan_addr_i];
  end

  assign cpu_rdata_o  = mem_q[cpu_addr_i];
  assign scan_rdata_o = scan_rdata_q;

endmodule

// File: rtl/hack_memory_map_scan.sv
// Hack data-memory map: RAM, screen buffer and read-only keyboard register on
// one CPU bus, with a buffered valid/ready screen scan-out stream and an
// illegal-write flag.
// Ports: clk, reset (async, active-high), bus (slave modport carrying the CPU,
//        keyboard and scan-out signals).
module hack_memory_map_scan import hack_mem_pkg::*; #(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned RAM_DEPTH    = DEF_RAM_DEPTH,
  parameter int unsigned SCREEN_DEPTH = DEF_SCREEN_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  hack_memory_map_scan_if.slave bus
);

  localparam int unsigned KBD_ADDR = kbd_addr(RAM_DEPTH, SCREEN_DEPTH);
  localparam int unsigned RAM_AW   = $clog2(RAM_DEPTH);
  localparam int unsigned SCR_AW   = $clog2(SCREEN_DEPTH);

  region_e           region_c;
  logic [SCR_AW-1:0] scr_addr_c;
  logic [WIDTH-1:0]  scr_rdata_c;
  logic [WIDTH-1:0]  out_c;
  logic              fetch_c;

  logic [WIDTH-1:0]  ram_q [RAM_DEPTH];
  logic [WIDTH-1:0]  kbd_q;
  logic              bus_err_q, bus_err_d;
  logic [SCR_AW-1:0] ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic              fs_q, fs_d;

  assign region_c   = decode_region(32'(bus.address), RAM_DEPTH, SCREEN_DEPTH);
  assign scr_addr_c = SCR_AW'(bus.address - ADDR_W'(RAM_DEPTH));

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.load && region_c == REG_RAM) ram_q[RAM_AW'(bus.address)] <= bus.in;
  end

  hack_screen_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (SCREEN_DEPTH)
  ) u_screen (
    .clk          (clk),
    .reset        (reset),
    .cpu_we_i     (bus.load && region_c == REG_SCREEN),
    .cpu_addr_i   (scr_addr_c),
    .cpu_wdata_i  (bus.in),
    .cpu_rdata_o  (scr_rdata_c),
    .scan_re_i    (fetch_c),
    .scan_addr_i  (ptr_q),
    .scan_rdata_o (bus.scan_data)
  );

  // Zero-latency CPU read mux.
  always_comb begin
    out_c = '0;
    unique case (region_c)
      REG_RAM:    out_c = ram_q[RAM_AW'(bus.address)];
      REG_SCREEN: out_c = scr_rdata_c;
      REG_KBD:    out_c = kbd_q;
      REG_NONE:   out_c = '0;
    endcase
  end

  assign bus_err_d = bus.load && (32'(bus.address) >= KBD_ADDR);

  // A new word is fetched whenever the output slot is empty or being drained.
  assign fetch_c = bus.scan_en && (!valid_q || bus.scan_ready) && !bus.scan_restart;

  // Scan-out next state: restart beats fetch, fetch beats drain.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    fs_d    = fs_q;
    if (bus.scan_restart) begin
      ptr_d   = '0;
      valid_d = 1'b0;
      fs_d    = 1'b0;
    end else if (fetch_c) begin
      ptr_d   = ptr_q + SCR_AW'(1);
      valid_d = 1'b1;
      fs_d    = (ptr_q == '0);
    end else if (valid_q && bus.scan_ready) begin
      valid_d = 1'b0;
      fs_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_q     <= '0;
      bus_err_q <= 1'b0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      kbd_q     <= bus.kbd_in;
      bus_err_q <= bus_err_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.out              = out_c;
  assign bus.bus_err          = bus_err_q;
  assign bus.scan_valid       = valid_q;
  assign bus.scan_frame_start = fs_q;

endmodule

// File: tb/tb_hack_memory_map_scan.sv
// Directed bench for hack_memory_map_scan with a behavioural memory-map model
// and a per-cycle compare process.
module tb_hack_memory_map_scan;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   run = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hack_memory_map_scan_if #(.WIDTH(16), .ADDR_W(15)) ifc ();

  hack_memory_map_scan dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // ---------------- behavioural model ----------------
  logic [15:0] ram_m [16384];
  logic [15:0] scr_m [8192];
  logic [15:0] kbd_m;
  logic        berr_m;
  logic        offer_m;      // a word is currently offered
  logic [15:0] offer_word_m; // its value
  int          offer_idx_m;  // its screen index
  int          next_idx_m;   // index of the next word the stream will fetch

  function automatic logic [15:0] m_read(input int a);
    if (a < 16384)       return ram_m[a];
    else if (a < 24576)  return scr_m[a - 16384];
    else if (a == 24576) return kbd_m;
    else                 return 16'h0000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_m = '0; berr_m = 1'b0; offer_m = 1'b0; offer_word_m = '0;
      offer_idx_m = 0; next_idx_m = 0;
    end else begin
      // stream: the scan observes the screen as it was before this edge
      if (ifc.scan_restart) begin
        offer_m = 1'b0;
        next_idx_m = 0;
      end else if (ifc.scan_en && (!offer_m || ifc.scan_ready)) begin
        offer_m      = 1'b1;
        offer_word_m = scr_m[next_idx_m];
        offer_idx_m  = next_idx_m;
        next_idx_m   = (next_idx_m + 1) % 8192;
      end else if (offer_m && ifc.scan_ready) begin
        offer_m = 1'b0;
      end
      berr_m = ifc.load && (int'(ifc.address) >= 24576);
      if (ifc.load) begin
        if (int'(ifc.address) < 16384) ram_m[int'(ifc.address)] = ifc.in;
        else if (int'(ifc.address) < 24576) scr_m[int'(ifc.address) - 16384] = ifc.in;
      end
      kbd_m = ifc.kbd_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [15:0] exp_out;
  always @(negedge clk) begin
    if (run && !reset) begin
      exp_out = m_read(int'(ifc.address));
      if (!$isunknown(exp_out)) check("out", 32'(ifc.out), 32'(exp_out));
      check("bus_err", 32'(ifc.bus_err), 32'(berr_m));
      check("scan_valid", 32'(ifc.scan_valid), 32'(offer_m));
      if (offer_m) begin
        if (!$isunknown(offer_word_m)) check("scan_data", 32'(ifc.scan_data), 32'(offer_word_m));
        check("scan_frame_start", 32'(ifc.scan_frame_start), 32'(offer_idx_m == 0));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_word(input int w, input int budget, input string name);
    int n = 0;
    while (!(ifc.scan_valid && ifc.scan_data == 16'(w)) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: word %0d not offered within %0d cycles", name, w, budget);
    end
  endtask

  initial begin
    ifc.in = '0; ifc.load = 1'b0; ifc.address = '0; ifc.kbd_in = '0;
    ifc.scan_en = 1'b0; ifc.scan_restart = 1'b0; ifc.scan_ready = 1'b0;
    #2 reset = 1'b1;
    ifc.kbd_in = 16'h00FF;
    ifc.address = 15'd24576;
    step(); step();
    check("rst_bus_err", 32'(ifc.bus_err), 32'h0);
    check("rst_scan_valid", 32'(ifc.scan_valid), 32'h0);
    check("rst_scan_data", 32'(ifc.scan_data), 32'h0);
    check("rst_frame_start", 32'(ifc.scan_frame_start), 32'h0);
    check("rst_kbd", 32'(ifc.out), 32'h0);
    reset = 1'b0;
    run = 1'b1;

    // RAM and screen write/readback
    ifc.load = 1'b1; ifc.address = 15'd5;     ifc.in = 16'h1234; step();
    ifc.address = 15'd16384; ifc.in = 16'hABCD; step();
    ifc.load = 1'b0;
    ifc.address = 15'd5;     #1 check("ram5", 32'(ifc.out), 32'h1234);
    ifc.address = 15'd16384; #1 check("screen0", 32'(ifc.out), 32'hABCD);

    // keyboard and illegal write
    ifc.kbd_in = 16'h0041; step(); step();
    ifc.address = 15'd24576; #1 check("kbd", 32'(ifc.out), 32'h0041);
    ifc.load = 1'b1; ifc.in = 16'hFFFF; step();
    ifc.load = 1'b0;
    check("bus_err_pulse", 32'(ifc.bus_err), 32'h1);
    check("kbd_ro", 32'(ifc.out), 32'h0041);
    step();
    check("bus_err_clear", 32'(ifc.bus_err), 32'h0);
    ifc.address = 15'd24577; #1 check("unmapped", 32'(ifc.out), 32'h0);

    // preload screen word i = i
    for (int i = 0; i < 8192; i++) begin
      ifc.load = 1'b1; ifc.address = 15'(16384 + i); ifc.in = 16'(i);
      step();
    end
    ifc.load = 1'b0; ifc.address = 15'd5;

    // streaming and wrap
    ifc.scan_ready = 1'b1; ifc.scan_en = 1'b1;
    wait_word(0, 4, "first_word");
    check("first_fs", 32'(ifc.scan_frame_start), 32'h1);
    step();
    check("second_word", 32'(ifc.scan_data), 32'h1);
    check("second_fs", 32'(ifc.scan_frame_start), 32'h0);
    wait_word(8191, 9000, "last_word");
    step();
    check("wrap_word", 32'(ifc.scan_data), 32'h0);
    check("wrap_fs", 32'(ifc.scan_frame_start), 32'h1);

    // stall on word 7
    wait_word(7, 20, "stall_word");
    ifc.scan_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_data", 32'(ifc.scan_data), 32'h7);
      check("stall_valid", 32'(ifc.scan_valid), 32'h1);
    end
    ifc.scan_ready = 1'b1;
    step();
    check("after_stall", 32'(ifc.scan_data), 32'h8);

    // collision: CPU writes word 10 on the edge the scan fetches it
    wait_word(9, 20, "pre_collide");
    ifc.load = 1'b1; ifc.address = 15'd16394; ifc.in = 16'h5555;
    step();
    ifc.load = 1'b0;
    check("collide_scan", 32'(ifc.scan_data), 32'd10);
    #1 check("collide_cpu", 32'(ifc.out), 32'h5555);

    // restart at word 100
    wait_word(100, 200, "pre_restart");
    ifc.scan_restart = 1'b1;
    step();
    ifc.scan_restart = 1'b0;
    check("restart_valid", 32'(ifc.scan_valid), 32'h0);
    step();
    check("restart_word", 32'(ifc.scan_data), 32'h0);
    check("restart_fs", 32'(ifc.scan_frame_start), 32'h1);

    // async reset at word 50
    wait_word(50, 100, "pre_reset");
    reset = 1'b1;
    #1 check("reset_valid", 32'(ifc.scan_valid), 32'h0);
    step();
    reset = 1'b0;
    step();
    check("reset_word", 32'(ifc.scan_data), 32'h0);
    check("reset_fs", 32'(ifc.scan_frame_start), 32'h1);
    ifc.address = 15'd5; #1 check("ram_survives", 32'(ifc.out), 32'h1234);
    step(); step();

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hack_memory_map_scan.md
Name: hack_memory_map_scan

Overview:
- Parametrised successor of the Hack data-memory map: RAM, screen buffer and keyboard register behind one CPU address bus.
- Adds a buffered screen scan-out port with a valid/ready handshake for a display controller.
- Keyboard register is fed from an external key-code input and is read-only to the CPU.
- Flags CPU writes to read-only or unmapped addresses; sits between the CPU data port and the display/keyboard front ends.

Parameters:
WIDTH, 16, data word width
ADDR_W, 15, CPU address width
RAM_DEPTH, 16384, RAM words, mapped at 0..RAM_DEPTH-1
SCREEN_DEPTH, 8192, screen words, mapped at RAM_DEPTH..RAM_DEPTH+SCREEN_DEPTH-1
(derived localparam) KBD_ADDR = RAM_DEPTH+SCREEN_DEPTH; must be < 2**ADDR_W; SCREEN_DEPTH must be a power of two

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in  in  WIDTH  CPU write data
load  in  1  CPU write enable
address  in  ADDR_W  CPU address
out  out  WIDTH  CPU read data, combinational
kbd_in  in  WIDTH  key code from keyboard front end (already in clk domain)
bus_err  out  1  one-cycle pulse: illegal write seen the previous cycle
scan_en  in  1  enable scan-out fetches
scan_restart  in  1  restart scan at screen word 0
scan_data  out  WIDTH  screen word being offered
scan_valid  out  1  scan_data valid
scan_ready  in  1  consumer accepts scan_data
scan_frame_start  out  1  high while offered word is screen word 0

Behaviour:
- Reset (async, active-high) clears keyboard reg, bus_err, scan_data, scan_valid, scan_frame_start and scan pointer to 0. RAM and screen contents are not cleared.
- CPU read (combinational, zero latency):
  - address < RAM_DEPTH -> ram[address]
  - address < KBD_ADDR -> screen[address-RAM_DEPTH]
  - address == KBD_ADDR -> keyboard reg
  - otherwise -> 0
- CPU write: on posedge with load=1, writes RAM or screen. No array write for address >= KBD_ADDR.
- bus_err: registered. Next cycle equals load && (address >= KBD_ADDR); returns to 0 when the condition is absent.
- Keyboard reg: keyboard <= kbd_in every cycle. CPU read returns the value captured at the previous edge (1-cycle latency from kbd_in).
- Scan pointer: log2(SCREEN_DEPTH) bits. Wraps SCREEN_DEPTH-1 -> 0 with no gap.
- Scan fetch: fires when scan_en && (!scan_valid || scan_ready) && !scan_restart. On fetch:
  - scan_data <= screen[ptr]
  - scan_frame_start <= (ptr==0)
  - scan_valid <= 1
  - ptr <= ptr+1
- Scan throughput: one word per cycle while scan_ready is held high.
- Stall: scan_valid && !scan_ready holds scan_data, scan_valid, scan_frame_start and ptr stable.
- scan_en low: no new fetch. The pending word stays valid until accepted; after acceptance scan_valid goes 0 and ptr is retained.
- scan_restart: priority over fetch. Next cycle ptr=0, scan_valid=0, scan_frame_start=0; any pending word is discarded.
- Same-cycle CPU write and scan fetch of the same screen word: scan gets the old value (read-before-write).
- Reset asserted mid-scan: immediate return to reset values; the scan resumes at word 0.

Decomposition:
- Shared package hack_mem_pkg: default WIDTH/ADDR_W/RAM_DEPTH/SCREEN_DEPTH, KBD_ADDR function, region-decode enum (REG_RAM, REG_SCREEN, REG_KBD, REG_NONE).
- One sub-module, hack_screen_dpram: screen array with a CPU read/write port and a synchronous scan read port, read-before-write on collision.
- Decode and scan control stay in the top module.

Test Plan:
- Write 16'h1234 to address 5 and 16'hABCD to address 16384 -> out reads back 16'h1234 and 16'hABCD; screen[0]=16'hABCD.
- kbd_in=16'h0041 for 2 cycles -> read of 24576 gives 16'h0041; write 16'hFFFF to 24576 -> value unchanged, bus_err=1 for exactly one cycle; address 24577 reads 0.
- Screen preloaded with word i = i; scan_en=1, scan_ready=1 -> scan_data 0,1,2,… one per cycle, scan_frame_start high only with word 0; after 8191 the stream wraps to 0 with frame_start high.
- scan_ready dropped for 3 cycles while word 7 offered -> scan_data=7, scan_valid=1 held stable; word 8 follows on the cycle after scan_ready returns.
- CPU writes 16'h5555 to screen word 10 in the same cycle the scan fetches word 10 -> scan gets the old value 10; a CPU read afterwards gives 16'h5555.
- scan_restart at word 100, then reset mid-scan at word 50 -> both times the next offered word is 0 with frame_start=1; RAM contents survive reset.
